// File: rtl/multi_divider.sv
// Run-time programmable multi-channel clock divider. Each channel produces a
// near-50% square wave plus a one-cycle tick; divisor changes apply only at period boundaries.
module multi_divider #(
    parameter int NCH     = 3,
    parameter int CW      = 32,
    parameter int DEF_DIV = 100000,
    parameter int AW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CP,
    input  logic           CR,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_ch,
    input  logic [CW-1:0]  wr_div,
    output logic [NCH-1:0] CLK_OUT,
    output logic [NCH-1:0] TICK,
    output logic [NCH-1:0] pend
);

    localparam logic [CW-1:0] DEF     = CW'(DEF_DIV);
    localparam logic [CW-1:0] MIN_DIV = CW'(2);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // Divisors below 2 cannot form a period, so they are clamped on write.
    logic [CW-1:0] wr_val;
    assign wr_val = (wr_div < MIN_DIV) ? MIN_DIV : wr_div;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [AW-1:0] CH = AW'(i);

        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] div_act_q, div_act_d;
        logic [CW-1:0] div_sh_q, div_sh_d;
        logic          pend_q, pend_d;
        logic          clk_q, tick_q, tick_d;
        logic          wrap, wr_hit, boundary;

        assign wrap   = (cnt_q == div_act_q - ONE);
        assign wr_hit = wr_en && (wr_ch == CH);

        always_comb begin
            // NOTE: every variable gets a default first, so no path can infer a latch.
            cnt_d     = cnt_q;
            div_act_d = div_act_q;
            div_sh_d  = div_sh_q;
            pend_d    = pend_q;
            tick_d    = 1'b0;
            boundary  = 1'b0;

            if (sync) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else if (en[i]) begin
                if (wrap) begin
                    cnt_d    = '0;
                    tick_d   = 1'b1;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            // The boundary consumes the pre-write shadow; a same-cycle write waits for the next one.
            if (boundary && pend_q) begin
                div_act_d = div_sh_q;
                pend_d    = 1'b0;
            end
            if (wr_hit) begin
                div_sh_d = wr_val;
                pend_d   = 1'b1;
            end
        end

        // NOTE: non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge CP or posedge CR) begin
            if (CR) begin
                cnt_q     <= '0;
                div_act_q <= DEF;
                div_sh_q  <= DEF;
                pend_q    <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                div_act_q <= div_act_d;
                div_sh_q  <= div_sh_d;
                pend_q    <= pend_d;
                clk_q     <= (cnt_d >= (div_act_d >> 1));
                tick_q    <= tick_d;
            end
        end

        assign CLK_OUT[i] = clk_q;
        assign TICK[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_multi_divider.sv
// Self-checking bench for multi_divider: per-cycle comparison against a phase/modulo
// reference model, a table of divisor writes, and hand-written pause/sync/reset sequences.
module tb_multi_divider;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int DEF = 10;
    localparam int AW  = 2;

    logic           CP = 1'b0;
    logic           CR = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_ch = '0;
    logic [CW-1:0]  wr_div = '0;
    logic [NCH-1:0] CLK_OUT, TICK, pend;

    multi_divider #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
        .CP(CP), .CR(CR), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .CLK_OUT(CLK_OUT), .TICK(TICK), .pend(pend)
    );

    always #5 CP = ~CP;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model: position within the period, active/shadow divisors, pending flag.
    int             m_phase [NCH];
    int             m_div   [NCH];
    int             m_sh    [NCH];
    logic [NCH-1:0] m_pend, m_clk, m_tick;

    typedef struct {
        logic [AW-1:0] ch;
        logic [CW-1:0] div;
        logic          exp_pend;
        int            exp_period;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;
            m_div[c]   = DEF;
            m_sh[c]    = DEF;
        end
        m_pend = '0;
        m_clk  = '0;
        m_tick = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit boundary;
            boundary  = 0;
            m_tick[c] = 1'b0;
            if (sync) begin
                m_phase[c] = 0;
                boundary   = 1;
            end else if (en[c]) begin
                m_phase[c] = (m_phase[c] + 1) % m_div[c];
                if (m_phase[c] == 0) begin
                    m_tick[c] = 1'b1;
                    boundary  = 1;
                end
            end
            if (boundary && m_pend[c]) begin
                m_div[c]  = m_sh[c];
                m_pend[c] = 1'b0;
            end
            if (wr_en && int'(wr_ch) == c) begin
                m_sh[c]   = (int'(wr_div) < 2) ? 2 : int'(wr_div);
                m_pend[c] = 1'b1;
            end
            m_clk[c] = (m_phase[c] >= m_div[c] / 2);
        end
    endtask

    // One CP cycle: advance model at the edge, compare 1 time unit later.
    task automatic cycle();
        @(posedge CP);
        model_step();
        cyc++;
        #1;
        check("clk_out", 32'(CLK_OUT), 32'(m_clk));
        check("tick", 32'(TICK), 32'(m_tick));
        check("pend", 32'(pend), 32'(m_pend));
    endtask

    task automatic do_reset();
        CR = 1'b1;
        en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        repeat (2) @(posedge CP);
        #1;
        check("reset_clk_out", 32'(CLK_OUT), 0);
        check("reset_tick", 32'(TICK), 0);
        check("reset_pend", 32'(pend), 0);
        @(negedge CP);
        CR = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    // Cycles until TICK[ch] is seen; a timeout returns the limit, which fails the caller's check.
    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!TICK[ch] && n < 200);
    endtask

    task automatic write(input int ch, input int div);
        wr_en  = 1'b1;
        wr_ch  = AW'(ch);
        wr_div = CW'(div);
        cycle();
        wr_en  = 1'b0;
    endtask

    initial begin
        int n;
        int first [NCH];

        vecs[0] = '{ch: 2'd1, div: 16'd5, exp_pend: 1'b1, exp_period: 5};
        vecs[1] = '{ch: 2'd2, div: 16'd0, exp_pend: 1'b1, exp_period: 2};
        vecs[2] = '{ch: 2'd2, div: 16'd1, exp_pend: 1'b1, exp_period: 2};
        vecs[3] = '{ch: 2'd0, div: 16'd7, exp_pend: 1'b1, exp_period: 7};
        vecs[4] = '{ch: 2'd3, div: 16'd9, exp_pend: 1'b0, exp_period: 10};
        vecs[5] = '{ch: 2'd0, div: 16'd2, exp_pend: 1'b1, exp_period: 2};

        // Default divisor: first tick 10 cycles after reset release, then every 10.
        do_reset();
        en = '1;
        wait_tick(0, n);
        check("def_first_tick", n, 10);
        wait_tick(2, n);
        check("def_period", n, 10);

        // Table: write at cycle 3, pending by cycle 4, applied at the cycle-10 wrap.
        foreach (vecs[k]) begin
            int ch_m;
            ch_m = (int'(vecs[k].ch) < NCH) ? int'(vecs[k].ch) : 0;
            do_reset();
            en = '1;
            repeat (2) cycle();
            write(int'(vecs[k].ch), int'(vecs[k].div));
            repeat (1) cycle();
            if (int'(vecs[k].ch) < NCH)
                check("tbl_pend", 32'(pend[vecs[k].ch]), 32'(vecs[k].exp_pend));
            else
                check("tbl_pend_ignored", 32'(pend), 0);
            wait_tick(ch_m, n);
            check("tbl_first_tick", n, 6);
            check("tbl_pend_cleared", 32'(pend), 0);
            wait_tick(ch_m, n);
            check("tbl_period", n, vecs[k].exp_period);
        end

        // Pause ch0 for 7 cycles at cnt=4: that period stretches to 17 cycles.
        do_reset();
        en = '1;
        repeat (4) cycle();
        en[0] = 1'b0;
        repeat (7) cycle();
        check("pause_clk_low", 32'(CLK_OUT[0]), 0);
        en[0] = 1'b1;
        wait_tick(0, n);
        check("pause_period", cyc, 17);

        // Sync with a same-cycle write to ch0 while ch1 already has 6 pending.
        do_reset();
        en = '1;
        repeat (2) cycle();
        write(1, 6);
        repeat (3) cycle();
        sync = 1'b1;
        write(0, 4);
        sync = 1'b0;
        check("sync_pend", 32'(pend), 32'b001);
        check("sync_clk", 32'(CLK_OUT), 0);
        for (int c = 0; c < NCH; c++) first[c] = 0;
        for (int t = 1; t <= 12; t++) begin
            cycle();
            for (int c = 0; c < NCH; c++)
                if (TICK[c] && first[c] == 0) first[c] = t;
        end
        check("sync_ch1_tick", first[1], 6);
        check("sync_ch0_tick", first[0], 10);
        check("sync_ch2_tick", first[2], 10);
        check("sync_pend_after", 32'(pend), 0);

        // Asynchronous reset mid-period with a write pending.
        write(2, 3);
        repeat (3) cycle();
        #2;
        CR = 1'b1;
        #1;
        check("async_clk", 32'(CLK_OUT), 0);
        check("async_tick", 32'(TICK), 0);
        check("async_pend", 32'(pend), 0);
        model_reset();
        @(negedge CP);
        CR = 1'b0;
        cyc = 0;
        wait_tick(2, n);
        check("async_restart", n, DEF);

        // Randomised traffic against the model, including out-of-range writes.
        for (int t = 0; t < 1500; t++) begin
            en     = NCH'($urandom);
            sync   = ($urandom_range(0, 39) == 0);
            wr_en  = ($urandom_range(0, 5) == 0);
            wr_ch  = AW'($urandom_range(0, 3));
            wr_div = CW'($urandom_range(0, 12));
            cycle();
        end
        wr_en = 1'b0;
        sync  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
